key_debounce_bank: RTL and testbench

KEY_DEBOUNCE_BANK -- requirements
Module: key_debounce_bank

---
 rtl/key_debounce_bank.sv | 196 +++++++++++++++++++
 tb/tb_key_debounce_bank.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce_bank.sv
// -----------------------------------------------------------------------------
// key_debounce_bank
//
// Purpose:
//   Bank of N_CH independent key/switch debouncers. Each raw input is brought
//   into the clock domain through a SYNC_STAGES-deep synchroniser. A new level
//   is accepted only after it has been seen unchanged for long enough. Edge
//   pulses (rise/fall) and a long-press pulse (hold) are produced per channel.
//
// Parameters:
//   N_CH        - number of channels (>= 1)
//   STABLE_CNT  - consecutive stable cycles before a new level is accepted (>= 1)
//   SYNC_STAGES - synchroniser depth (>= 2)
//   HOLD_CNT    - debounced-high cycles before a hold pulse; 0 disables hold
//
// Ports:
//   clk       in   clock, all logic on the rising edge
//   rst_n     in   asynchronous active-low reset
//   din       in   [N_CH] raw asynchronous levels
//   dout      out  [N_CH] debounced level (registered)
//   rise      out  [N_CH] one-cycle pulse when dout goes 0->1 (registered)
//   fall      out  [N_CH] one-cycle pulse when dout goes 1->0 (registered)
//   hold      out  [N_CH] one-cycle pulse after a sustained high (registered)
//   any_event out  OR of every rise, fall and hold bit (combinational)
// -----------------------------------------------------------------------------

// Structural invariants on the outputs; simulation only.
module key_debounce_bank_chk #(
  parameter int N_CH = 2
) (
  input logic            clk,
  input logic            rst_n,
  input logic [N_CH-1:0] dout,
  input logic [N_CH-1:0] rise,
  input logic [N_CH-1:0] fall,
  input logic [N_CH-1:0] hold,
  input logic            any_event
);

  a_rise_fall_excl: assert property (@(posedge clk) disable iff (!rst_n)
    (rise & fall) == '0);

  a_rise_shows_high: assert property (@(posedge clk) disable iff (!rst_n)
    (rise & ~dout) == '0);

  a_fall_shows_low: assert property (@(posedge clk) disable iff (!rst_n)
    (fall & dout) == '0);

  a_any_event: assert property (@(posedge clk) disable iff (!rst_n)
    any_event == (|{rise, fall, hold}));

endmodule

module key_debounce_bank #(
  parameter int N_CH        = 2,
  parameter int STABLE_CNT  = 20,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CNT    = 1000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] din,
  output logic [N_CH-1:0] dout,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic [N_CH-1:0] hold,
  output logic            any_event
);

  // Counter widths. The hold counter keeps one bit when hold is disabled so
  // that no zero-width vector is ever declared.
  localparam int CW  = $clog2(STABLE_CNT + 1);
  localparam int HCW = (HOLD_CNT > 0) ? $clog2(HOLD_CNT + 1) : 1;

  localparam logic [CW-1:0]  CNT_LAST  = CW'(STABLE_CNT - 1);
  localparam logic [CW-1:0]  CNT_ONE   = CW'(1);
  localparam logic [HCW-1:0] HCNT_MAX  = HCW'(HOLD_CNT);
  localparam logic [HCW-1:0] HCNT_LAST = (HOLD_CNT > 0) ? HCW'(HOLD_CNT - 1) : HCW'(0);
  localparam logic [HCW-1:0] HCNT_ONE  = HCW'(1);
  localparam bit             HOLD_EN   = (HOLD_CNT > 0);

  // Synchroniser: index 0 is the first flop, index SYNC_STAGES-1 the last.
  logic [SYNC_STAGES-1:0][N_CH-1:0] sync_q;
  logic [N_CH-1:0]                  samp;

  // Debounce state
  logic [N_CH-1:0]          cand_q, cand_d;
  logic [N_CH-1:0][CW-1:0]  cnt_q,  cnt_d;
  logic [N_CH-1:0]          dout_q, dout_d;
  logic [N_CH-1:0]          rise_q, rise_d;
  logic [N_CH-1:0]          fall_q, fall_d;

  // Long-press state
  logic [N_CH-1:0][HCW-1:0] hcnt_q, hcnt_d;
  logic [N_CH-1:0]          hold_q, hold_d;

  // Synchroniser shift chain; new din enters at stage 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
    end
  end

  assign samp = sync_q[SYNC_STAGES-1];

  // Debounce next-state: candidate tracks the synchronised level, counter
  // measures how long it has stayed put while disagreeing with dout.
  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    dout_d = dout_q;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (samp[i] != cand_q[i]) begin
        // Any change at the synchroniser output restarts the measurement.
        cand_d[i] = samp[i];
        cnt_d[i]  = '0;
      end else if (cand_q[i] != dout_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          // Candidate has been stable long enough: accept it and flag the edge
          // in the same cycle that dout first shows it.
          dout_d[i] = cand_q[i];
          cnt_d[i]  = '0;
          rise_d[i] = cand_q[i];
          fall_d[i] = ~cand_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end else begin
        cnt_d[i] = '0;
      end
    end
  end

  // Long-press next-state: count debounced-high cycles, saturating, and pulse
  // once on the step into saturation.
  always_comb begin
    hcnt_d = hcnt_q;
    hold_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (!HOLD_EN) begin
        hcnt_d[i] = '0;
      end else if (!dout_q[i]) begin
        hcnt_d[i] = '0;
      end else if (hcnt_q[i] != HCNT_MAX) begin
        hcnt_d[i] = hcnt_q[i] + HCNT_ONE;
        hold_d[i] = (hcnt_q[i] == HCNT_LAST);
      end else begin
        hcnt_d[i] = hcnt_q[i];
      end
    end
  end

  // Debounce and long-press state registers, including the registered pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_q <= '0;
      cnt_q  <= '0;
      dout_q <= '0;
      rise_q <= '0;
      fall_q <= '0;
      hcnt_q <= '0;
      hold_q <= '0;
    end else begin
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      hcnt_q <= hcnt_d;
      hold_q <= hold_d;
    end
  end

  assign dout      = dout_q;
  assign rise      = rise_q;
  assign fall      = fall_q;
  assign hold      = hold_q;
  assign any_event = |{rise_q, fall_q, hold_q};

  key_debounce_bank_chk #(
    .N_CH (N_CH)
  ) u_chk (
    .clk       (clk),
    .rst_n     (rst_n),
    .dout      (dout_q),
    .rise      (rise_q),
    .fall      (fall_q),
    .hold      (hold_q),
    .any_event (any_event)
  );

endmodule

// File: tb/tb_key_debounce_bank.sv
// -----------------------------------------------------------------------------
// tb_key_debounce_bank
//
// Two instances: A (N_CH=4, STABLE_CNT=20, SYNC_STAGES=2, HOLD_CNT=50) and
// B (N_CH=2, STABLE_CNT=1, SYNC_STAGES=3, HOLD_CNT=0). Every clock is compared
// against a reference model that applies the debounce rule directly to a
// history window of sampled din values: a channel takes level v once the
// samples taken SYNC_STAGES..SYNC_STAGES+STABLE_CNT edges ago are all v. A
// hold is expected exactly HOLD_CNT edges after a rise while still high.
// -----------------------------------------------------------------------------
module tb_key_debounce_bank;

  localparam int HD = 32;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] din_a;
  logic [1:0] din_b;
  logic [3:0] dout_a, rise_a, fall_a, hold_a;
  logic       any_a;
  logic [1:0] dout_b, rise_b, fall_b, hold_b;
  logic       any_b;

  always #5 clk = ~clk;

  key_debounce_bank #(
    .N_CH(4), .STABLE_CNT(20), .SYNC_STAGES(2), .HOLD_CNT(50)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n), .din(din_a), .dout(dout_a), .rise(rise_a),
    .fall(fall_a), .hold(hold_a), .any_event(any_a)
  );

  key_debounce_bank #(
    .N_CH(2), .STABLE_CNT(1), .SYNC_STAGES(3), .HOLD_CNT(0)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .din(din_b), .dout(dout_b), .rise(rise_b),
    .fall(fall_b), .hold(hold_b), .any_event(any_b)
  );

  // Reference model state, index 0 = instance A, 1 = instance B
  int         m_nch    [2] = '{4, 2};
  int         m_sync   [2] = '{2, 3};
  int         m_stable [2] = '{20, 1};
  int         m_hold   [2] = '{50, 0};
  logic [3:0] hist     [2][HD];
  logic [3:0] e_dout   [2];
  logic [3:0] e_rise   [2];
  logic [3:0] e_fall   [2];
  logic [3:0] e_hold   [2];
  int         rise_cyc [2][4];
  int         cyc;

  int checks;
  int errors;

  typedef struct {
    logic [3:0] din;
    int         n;
    logic [3:0] dout;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] hold;
  } vec_t;

  vec_t tbl [10];

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int k = 0; k < HD; k++) hist[m][k] = 4'b0000;
      e_dout[m] = 4'b0000;
      e_rise[m] = 4'b0000;
      e_fall[m] = 4'b0000;
      e_hold[m] = 4'b0000;
    end
  endtask

  task automatic model_edge(input int m, input logic [3:0] smp);
    logic [3:0] prev;
    for (int k = HD - 1; k > 0; k--) hist[m][k] = hist[m][k-1];
    hist[m][0] = smp;
    prev = e_dout[m];
    e_rise[m] = 4'b0000;
    e_fall[m] = 4'b0000;
    e_hold[m] = 4'b0000;
    for (int i = 0; i < m_nch[m]; i++) begin
      bit all1;
      bit all0;
      all1 = 1'b1;
      all0 = 1'b1;
      for (int k = m_sync[m]; k <= m_sync[m] + m_stable[m]; k++) begin
        if (hist[m][k][i]) all0 = 1'b0;
        else               all1 = 1'b0;
      end
      if (!prev[i] && all1) begin
        e_dout[m][i] = 1'b1;
        e_rise[m][i] = 1'b1;
        rise_cyc[m][i] = cyc;
      end else if (prev[i] && all0) begin
        e_dout[m][i] = 1'b0;
        e_fall[m][i] = 1'b1;
      end
      if (m_hold[m] > 0 && prev[i] && (cyc - rise_cyc[m][i] == m_hold[m]))
        e_hold[m][i] = 1'b1;
    end
  endtask

  task automatic compare_all();
    check("dout_a", dout_a, e_dout[0]);
    check("rise_a", rise_a, e_rise[0]);
    check("fall_a", fall_a, e_fall[0]);
    check("hold_a", hold_a, e_hold[0]);
    check("any_a", {3'b000, any_a}, {3'b000, |(e_rise[0] | e_fall[0] | e_hold[0])});
    check("dout_b", {2'b00, dout_b}, e_dout[1]);
    check("rise_b", {2'b00, rise_b}, e_rise[1]);
    check("fall_b", {2'b00, fall_b}, e_fall[1]);
    check("hold_b", {2'b00, hold_b}, e_hold[1]);
    check("any_b", {3'b000, any_b}, {3'b000, |(e_rise[1] | e_fall[1] | e_hold[1])});
  endtask

  // One clock: drive, clock, update model, compare away from the edge.
  task automatic step(input logic [3:0] da, input logic [1:0] db);
    din_a = da;
    din_b = db;
    @(posedge clk);
    cyc++;
    model_edge(0, da);
    model_edge(1, {2'b00, db});
    #1;
    compare_all();
  endtask

  task automatic apply_reset(input int n);
    rst_n = 1'b0;
    #1;
    check("rst_dout_a", dout_a, 4'b0000);
    check("rst_rise_a", rise_a, 4'b0000);
    check("rst_hold_a", hold_a, 4'b0000);
    check("rst_any_a", {3'b000, any_a}, 4'b0000);
    check("rst_dout_b", {2'b00, dout_b}, 4'b0000);
    model_reset();
    repeat (n) @(posedge clk);
    #1;
    check("rst_held_dout_a", dout_a, 4'b0000);
    check("rst_held_fall_a", fall_a, 4'b0000);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int nrise;
    int rise_at;
    int first_at;
    logic [3:0] first_val;
    int rem [6];
    logic [5:0] lv;

    checks = 0;
    errors = 0;
    cyc    = 0;
    rst_n  = 1'b0;
    din_a  = 4'b0000;
    din_b  = 2'b00;
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < 4; i++) rise_cyc[m][i] = 0;
    model_reset();

    tbl[0] = '{4'b1011, 22, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tbl[1] = '{4'b1011,  1, 4'b1011, 4'b1011, 4'b0000, 4'b0000};
    tbl[2] = '{4'b1011,  1, 4'b1011, 4'b0000, 4'b0000, 4'b0000};
    tbl[3] = '{4'b1011, 48, 4'b1011, 4'b0000, 4'b0000, 4'b0000};
    tbl[4] = '{4'b1011,  1, 4'b1011, 4'b0000, 4'b0000, 4'b1011};
    tbl[5] = '{4'b1011,  1, 4'b1011, 4'b0000, 4'b0000, 4'b0000};
    tbl[6] = '{4'b0000, 22, 4'b1011, 4'b0000, 4'b0000, 4'b0000};
    tbl[7] = '{4'b0000,  1, 4'b0000, 4'b0000, 4'b1011, 4'b0000};
    tbl[8] = '{4'b0010, 10, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tbl[9] = '{4'b0000, 30, 4'b0000, 4'b0000, 4'b0000, 4'b0000};

    repeat (2) @(posedge clk);
    #1;
    apply_reset(3);

    // Directed table on instance A (B sees the low two bits)
    for (int t = 0; t < 10; t++) begin
      for (int j = 0; j < tbl[t].n; j++) step(tbl[t].din, tbl[t].din[1:0]);
      check($sformatf("tbl%0d_dout", t), dout_a, tbl[t].dout);
      check($sformatf("tbl%0d_rise", t), rise_a, tbl[t].rise);
      check($sformatf("tbl%0d_fall", t), fall_a, tbl[t].fall);
      check($sformatf("tbl%0d_hold", t), hold_a, tbl[t].hold);
      check($sformatf("tbl%0d_any", t), {3'b000, any_a},
            {3'b000, |(tbl[t].rise | tbl[t].fall | tbl[t].hold)});
    end

    // Instance B latency: SYNC_STAGES+STABLE_CNT = 4 edges after first sample
    repeat (4) step(4'b0000, 2'b01);
    check("b_rise_pre", {2'b00, dout_b}, 4'b0000);
    step(4'b0000, 2'b01);
    check("b_rise_dout", {2'b00, dout_b}, 4'b0001);
    check("b_rise_pulse", {2'b00, rise_b}, 4'b0001);
    repeat (4) step(4'b0000, 2'b00);
    check("b_fall_pre", {2'b00, dout_b}, 4'b0001);
    step(4'b0000, 2'b00);
    check("b_fall_dout", {2'b00, dout_b}, 4'b0000);
    check("b_fall_pulse", {2'b00, fall_b}, 4'b0001);
    repeat (5) step(4'b0000, 2'b00);

    // Bounce on A ch0 every 3 cycles, then settle high
    for (int k = 0; k < 16; k++) begin
      logic lvl;
      lvl = (k % 2 == 0) ? 1'b1 : 1'b0;
      repeat (3) step({3'b000, lvl}, 2'b00);
    end
    nrise   = 0;
    rise_at = 0;
    for (int s = 1; s <= 40; s++) begin
      step(4'b0001, 2'b00);
      if (rise_a[0]) begin
        nrise++;
        if (rise_at == 0) rise_at = s;
      end
    end
    check_int("bounce_nrise", nrise, 1);
    check_int("bounce_rise_at", rise_at, 23);
    repeat (30) step(4'b0000, 2'b00);

    // Reset 15 cycles into a ch0 rise, with ch1 already debounced high
    repeat (25) step(4'b0010, 2'b00);
    check("pre_rst_dout", dout_a, 4'b0010);
    repeat (15) step(4'b0011, 2'b00);
    apply_reset(3);
    first_at  = 0;
    first_val = 4'b0000;
    for (int s = 1; s <= 30; s++) begin
      step(4'b0011, 2'b00);
      if (first_at == 0 && rise_a != 4'b0000) begin
        first_at  = s;
        first_val = rise_a;
      end
    end
    check_int("rst_rise_at", first_at, 23);
    check("rst_rise_val", first_val, 4'b0011);

    // Randomised run lengths on all six channels, one reset in the middle
    lv = {2'b00, 4'b0011};
    for (int c = 0; c < 6; c++) rem[c] = 0;
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < 6; c++) begin
        if (rem[c] == 0) begin
          lv[c] = ~lv[c];
          if ($urandom_range(0, 3) == 0) rem[c] = int'($urandom_range(60, 130));
          else                           rem[c] = int'($urandom_range(1, 30));
        end else begin
          rem[c] = rem[c] - 1;
        end
      end
      if (n == 1500) apply_reset(2);
      step(lv[3:0], lv[5:4]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
